// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit and its
// reusable combinational op slice.
package logic_unit_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe; slave is the unit,
// master is the producer/consumer side that drives operands and out_ready.
interface logic_unit_pipe_if #(
    parameter int W = 8
);
    import logic_unit_pipe_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [OP_W-1:0] in_op;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_y;
    logic            out_zero;
    logic            out_rand;
    logic            out_ror;

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_rand, out_ror
    );

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_rand, out_ror
    );

endinterface

// File: rtl/logic_unit_pipe_op_slice.sv
// Purely combinational W-bit two-operand logic function selected by opcode;
// kept standalone so other datapath blocks can reuse it.
module logic_op_slice
    import logic_unit_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  op_e          i_op,
    output logic [W-1:0] o_y
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_y and no latch is inferred.
        o_y = '0;
        case (i_op)
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NAND: o_y = ~(i_a & i_b);
            OP_NOR:  o_y = ~(i_a | i_b);
            OP_XNOR: o_y = ~(i_a ^ i_b);
            OP_ANDN: o_y = i_a & ~i_b;
            OP_PASS: o_y = i_a;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_op_slice: S1 holds operands,
// S2 holds the result plus registered zero / reduction-AND / reduction-OR flags.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    logic_unit_pipe_if.slave  bus
);

    logic         r_s1_valid;
    logic [W-1:0] r_s1_a;
    logic [W-1:0] r_s1_b;
    op_e          r_s1_op;

    logic         r_s2_valid;
    logic [W-1:0] r_y;
    logic         r_zero;
    logic         r_rand;
    logic         r_ror;

    logic         w_s2_adv;
    logic         w_s1_adv;
    logic         w_in_fire;
    logic         w_s1_fire;
    logic [W-1:0] w_y;

    // in_ready depends only on stage occupancy and out_ready, never on in_valid.
    assign w_s2_adv  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign w_in_fire = bus.in_valid && w_s1_adv;
    assign w_s1_fire = r_s1_valid && w_s2_adv;

    assign bus.in_ready = w_s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are plain flops, so resetting them is cheap and keeps X out of simulation.
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_AND;
        end else begin
            // NOTE: non-blocking assignments so every stage samples pre-edge values.
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_a  <= bus.in_a;
                r_s1_b  <= bus.in_b;
                r_s1_op <= op_e'(bus.in_op);
            end
        end
    end

    logic_op_slice #(.W(W)) u_op_slice (
        .i_a  (r_s1_a),
        .i_b  (r_s1_b),
        .i_op (r_s1_op),
        .o_y  (w_y)
    );

    // Flags are derived from the slice output and registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_zero     <= 1'b1;
            r_rand     <= 1'b0;
            r_ror      <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_fire) begin
                r_y    <= w_y;
                r_zero <= ~|w_y;
                r_rand <= &w_y;
                r_ror  <= |w_y;
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_y     = r_y;
    assign bus.out_zero  = r_zero;
    assign bus.out_rand  = r_rand;
    assign bus.out_ror   = r_ror;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed checks on a W=8 unit plus a randomized scoreboard soak on a W=13 unit.
module tb_logic_unit_pipe;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic_unit_pipe_if #(.W(8))  bus8 ();
    logic_unit_pipe_if #(.W(13)) bus13 ();

    logic_unit_pipe #(.W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    logic_unit_pipe #(.W(13)) u_dut13 (
        .clk (clk),
        .rst (rst),
        .bus (bus13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed vector table: operands, opcode, hand-computed result and {zero,rand,ror}.
    logic [7:0] va  [8];
    logic [7:0] vb  [8];
    logic [2:0] vop [8];
    logic [7:0] vy  [8];
    logic [2:0] vf  [8];

    // Streams n beats with out_ready high; each result must appear exactly 2 cycles later.
    task automatic run_vec(input int n, input string tag);
        bus8.out_ready = 1'b1;
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 2 && i - 2 < n) begin
                check($sformatf("%s_valid%0d", tag, i - 2), 32'(bus8.out_valid), 32'd1);
                check($sformatf("%s_y%0d", tag, i - 2), 32'(bus8.out_y), 32'(vy[i-2]));
                check($sformatf("%s_flags%0d", tag, i - 2),
                      32'({bus8.out_zero, bus8.out_rand, bus8.out_ror}), 32'(vf[i-2]));
            end else begin
                check($sformatf("%s_idle%0d", tag, i), 32'(bus8.out_valid), 32'd0);
            end
            if (i < n) begin
                bus8.in_valid = 1'b1;
                bus8.in_a     = va[i];
                bus8.in_b     = vb[i];
                bus8.in_op    = vop[i];
            end else begin
                bus8.in_valid = 1'b0;
            end
            step();
        end
    endtask

    function automatic logic [12:0] model13(input logic [12:0] a, input logic [12:0] b,
                                            input logic [2:0] op);
        logic [12:0] y;
        case (op)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: y = a ^ b;
            3'd3: y = ~(a & b);
            3'd4: y = ~(a | b);
            3'd5: y = ~(a ^ b);
            3'd6: y = a & ~b;
            default: y = a;
        endcase
        return y;
    endfunction

    initial begin
        logic [7:0] bp_exp [4];
        logic [7:0] bp_a   [4];
        logic [2:0] bp_op  [4];
        int         idx;
        int         got;
        logic       fire_in;
        logic       fire_out;

        rst = 1'b1;
        bus8.in_valid  = 1'b0;
        bus8.in_a      = '0;
        bus8.in_b      = '0;
        bus8.in_op     = '0;
        bus8.out_ready = 1'b1;
        bus13.in_valid  = 1'b0;
        bus13.in_a      = '0;
        bus13.in_b      = '0;
        bus13.in_op     = '0;
        bus13.out_ready = 1'b0;

        // Reset state, observed while rst is held.
        #12;
        check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst_out_y",     32'(bus8.out_y),     32'h0);
        check("rst_flags",     32'({bus8.out_zero, bus8.out_rand, bus8.out_ror}), 32'b100);
        rst = 1'b0;
        step();

        // All eight opcodes on a=F0 b=3C, back to back.
        vy = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'hF0};
        for (int k = 0; k < 8; k++) begin
            va[k]  = 8'hF0;
            vb[k]  = 8'h3C;
            vop[k] = 3'(k);
            vf[k]  = 3'b001;
        end
        run_vec(8, "ops");

        // Flag extremes: all ones, then all zeros.
        va[0] = 8'hFF; vb[0] = 8'hFF; vop[0] = 3'd0; vy[0] = 8'hFF; vf[0] = 3'b011;
        va[1] = 8'hFF; vb[1] = 8'hFF; vop[1] = 3'd2; vy[1] = 8'h00; vf[1] = 3'b100;
        run_vec(2, "flags");

        // Backpressure: four beats into a stalled consumer, then release.
        bp_a   = '{8'h12, 8'h34, 8'h56, 8'h78};
        bp_op  = '{3'd0, 3'd1, 3'd2, 3'd7};
        bp_exp = '{8'h10, 8'hF4, 8'hA6, 8'h78};
        idx = 0;
        got = 0;
        bus8.out_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            if (cyc == 6) bus8.out_ready = 1'b1;
            if (idx < 4) begin
                bus8.in_valid = 1'b1;
                bus8.in_a     = bp_a[idx];
                bus8.in_b     = 8'hF0;
                bus8.in_op    = bp_op[idx];
            end else begin
                bus8.in_valid = 1'b0;
            end
            #1;
            if (cyc == 4) begin
                check("bp_in_ready_low", 32'(bus8.in_ready),  32'd0);
                check("bp_accepts",      32'(idx),            32'd2);
                check("bp_out_valid",    32'(bus8.out_valid), 32'd1);
                check("bp_hold_y4",      32'(bus8.out_y),     32'h10);
            end
            if (cyc == 5) check("bp_hold_y5", 32'(bus8.out_y), 32'h10);
            fire_in  = bus8.in_valid && bus8.in_ready;
            fire_out = bus8.out_valid && bus8.out_ready;
            if (fire_out) begin
                check($sformatf("bp_order%0d", got), 32'(bus8.out_y), 32'(bp_exp[got]));
                got++;
            end
            step();
            if (fire_in) idx++;
        end
        bus8.in_valid = 1'b0;
        check("bp_count", 32'(got), 32'd4);
        check("bp_drain", 32'(bus8.out_valid), 32'd0);
        step();

        // Simultaneous accept in and out with both stages full.
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in_a = 8'hAA; bus8.in_b = 8'h55; bus8.in_op = 3'd1;
        step();
        bus8.in_valid = 1'b1; bus8.in_a = 8'hAA; bus8.in_b = 8'h55; bus8.in_op = 3'd0;
        step();
        bus8.in_valid = 1'b0;
        #1;
        check("sim_full_in_ready", 32'(bus8.in_ready), 32'd0);
        check("sim_full_y",        32'(bus8.out_y),    32'hFF);
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_a = 8'hAA; bus8.in_b = 8'h0F; bus8.in_op = 3'd6;
        #1;
        check("sim_in_ready", 32'(bus8.in_ready), 32'd1);
        step();
        bus8.in_valid = 1'b0;
        check("sim_second", 32'({bus8.out_valid, bus8.out_y}), 32'h100);
        step();
        check("sim_third", 32'({bus8.out_valid, bus8.out_y}), 32'h1A0);
        step();
        check("sim_empty", 32'(bus8.out_valid), 32'd0);

        // Asynchronous reset with both stages full, then a clean restart.
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.in_a = 8'h5A; bus8.in_b = 8'hFF; bus8.in_op = 3'd7;
        step();
        bus8.in_valid = 1'b1; bus8.in_a = 8'h5A; bus8.in_b = 8'h0F; bus8.in_op = 3'd1;
        step();
        bus8.in_valid = 1'b0;
        check("rs_pre_valid", 32'(bus8.out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("rs_out_valid", 32'(bus8.out_valid), 32'd0);
        check("rs_out_y",     32'(bus8.out_y),     32'h0);
        check("rs_zero",      32'(bus8.out_zero),  32'd1);
        check("rs_in_ready",  32'(bus8.in_ready),  32'd1);
        #2;
        rst = 1'b0;
        step();
        va[0] = 8'hC3; vb[0] = 8'h3C; vop[0] = 3'd2; vy[0] = 8'hFF; vf[0] = 3'b011;
        run_vec(1, "rs_restart");

        // Random soak on the W=13 instance against the opcode model.
        begin
            logic [15:0] sb[$];
            logic [12:0] a13, b13, y13, held;
            logic [2:0]  op13;
            logic        stalled;
            int          n_in;
            int          n_out;
            n_in = 0;
            n_out = 0;
            stalled = 1'b0;
            held = '0;
            for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
                if (stalled) begin
                    check("soak_hold", 32'({bus13.out_valid, bus13.out_y}), 32'({1'b1, held}));
                end
                bus13.out_ready = ($urandom_range(0, 3) != 0);
                if (n_in < 10000 && $urandom_range(0, 3) != 0) begin
                    a13  = 13'($urandom);
                    b13  = 13'($urandom);
                    op13 = 3'($urandom_range(0, 7));
                    bus13.in_valid = 1'b1;
                    bus13.in_a     = a13;
                    bus13.in_b     = b13;
                    bus13.in_op    = op13;
                end else begin
                    bus13.in_valid = 1'b0;
                end
                #1;
                if (bus13.out_valid && bus13.out_ready) begin
                    if (sb.size() == 0) begin
                        check("soak_underflow", 32'd1, 32'd0);
                    end else begin
                        check("soak_beat",
                              32'({bus13.out_y, bus13.out_zero, bus13.out_rand, bus13.out_ror}),
                              32'(sb.pop_front()));
                    end
                    n_out++;
                end
                stalled = bus13.out_valid && !bus13.out_ready;
                held = bus13.out_y;
                if (bus13.in_valid && bus13.in_ready) begin
                    y13 = model13(bus13.in_a, bus13.in_b, bus13.in_op);
                    sb.push_back({y13, (y13 == 13'h0), (y13 == 13'h1FFF), (y13 != 13'h0)});
                    n_in++;
                end
                step();
            end
            bus13.in_valid = 1'b0;
            check("soak_out_count", 32'(n_out), 32'd10000);
            check("soak_sb_empty",  32'(sb.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
